// File: rtl/addr_cache_ctrl_pkg.sv
// Shared geometry, FSM state encoding and word-select helper for the address cache.
package addr_cache_ctrl_pkg;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned INDEX_W  = 10;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BLK_W    = WORD_W << OFFSET_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_MISS    = 3'd2,
    ST_RESPOND = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Pick one word out of a block; word 0 lives in the low bits.
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0]    blk,
                                                 input logic [OFFSET_W-1:0] off);
    return blk[WORD_W*32'(off) +: WORD_W];
  endfunction

endpackage

// File: rtl/addr_cache_ctrl_line_store.sv
// Direct-mapped line storage: valid bits (resettable), tag and data arrays (no reset).
module cache_line_store
  import addr_cache_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W    = addr_cache_ctrl_pkg::INDEX_W,
  parameter int unsigned TAG_BITS = addr_cache_ctrl_pkg::TAG_W,
  parameter int unsigned LINE_W   = addr_cache_ctrl_pkg::BLK_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [LINE_W-1:0]   wr_blk,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_vld_c,
  output logic [TAG_BITS-1:0] rd_tag_c,
  output logic [LINE_W-1:0]   rd_blk_c
);

  localparam int unsigned LINES = 2 ** IDX_W;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [LINE_W-1:0]   data_mem [LINES];

  // Mark the written line valid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // Valid bits are the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_blk;
    end
  end

  assign rd_vld_c = valid_q[rd_idx];
  assign rd_tag_c = tag_mem[rd_idx];
  assign rd_blk_c = data_mem[rd_idx];

endmodule

// File: rtl/addr_cache_ctrl.sv
// Single-outstanding direct-mapped read cache between an address reader and backing memory.
module addr_cache_ctrl #(
  parameter int unsigned ADDR_W   = addr_cache_ctrl_pkg::ADDR_W,
  parameter int unsigned INDEX_W  = addr_cache_ctrl_pkg::INDEX_W,
  parameter int unsigned OFFSET_W = addr_cache_ctrl_pkg::OFFSET_W,
  parameter int unsigned CNT_W    = addr_cache_ctrl_pkg::CNT_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 addr_valid,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic                                 data_finish,
  output logic                                 addr_ready,
  output logic                                 mem_req,
  output logic [ADDR_W-OFFSET_W-1:0]           mem_blk_addr,
  input  logic                                 mem_ack,
  input  logic [addr_cache_ctrl_pkg::BLK_W-1:0] mem_rdata,
  output logic                                 rd_valid,
  output logic [addr_cache_ctrl_pkg::WORD_W-1:0] rd_data,
  output logic                                 hit,
  output logic [CNT_W-1:0]                     hit_count,
  output logic [CNT_W-1:0]                     access_count,
  output logic                                 done
);

  import addr_cache_ctrl_pkg::*;

  localparam int unsigned LTAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned BLKA_W = ADDR_W - OFFSET_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                fin_q, fin_d;
  logic                addr_ready_q, addr_ready_d;
  logic                mem_req_q, mem_req_d;
  logic [BLKA_W-1:0]   mem_blk_q, mem_blk_d;
  logic                rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                hit_q, hit_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic                done_q, done_d;

  logic [OFFSET_W-1:0] req_off;
  logic [INDEX_W-1:0]  req_idx;
  logic [LTAG_W-1:0]   req_tag;
  logic                line_we;
  logic                line_vld;
  logic [LTAG_W-1:0]   line_tag;
  logic [BLK_W-1:0]    line_blk;

  assign req_off = addr_q[OFFSET_W-1:0];
  assign req_idx = addr_q[OFFSET_W +: INDEX_W];
  assign req_tag = addr_q[ADDR_W-1 -: LTAG_W];

  // Line storage; read and write both address the captured request's line.
  cache_line_store #(
    .IDX_W    (INDEX_W),
    .TAG_BITS (LTAG_W),
    .LINE_W   (BLK_W)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (line_we),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_blk   (mem_rdata),
    .rd_idx   (req_idx),
    .rd_vld_c (line_vld),
    .rd_tag_c (line_tag),
    .rd_blk_c (line_blk)
  );

  // Next-state, line fill and registered-output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    fin_d     = fin_q;
    rd_data_d = rd_data_q;
    hit_d     = 1'b0;
    line_we   = 1'b0;
    hit_cnt_d = hit_cnt_q;
    acc_cnt_d = acc_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (addr_valid) begin
          addr_d  = addr;
          fin_d   = data_finish;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (line_vld && (line_tag == req_tag)) begin
          hit_d     = 1'b1;
          rd_data_d = word_sel(line_blk, req_off);
          state_d   = ST_RESPOND;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        if (mem_ack) begin
          line_we   = rst;
          rd_data_d = word_sel(mem_rdata, req_off);
          state_d   = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        state_d = fin_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Counters advance together with the response strobe and stick at all-ones.
    if (state_d == ST_RESPOND) begin
      if (acc_cnt_q != {CNT_W{1'b1}}) begin
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end
      if (hit_d && (hit_cnt_q != {CNT_W{1'b1}})) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
    end

    addr_ready_d = (state_d == ST_IDLE);
    mem_req_d    = (state_d == ST_MISS);
    rd_valid_d   = (state_d == ST_RESPOND);
    done_d       = (state_d == ST_DONE);
    mem_blk_d    = addr_d[ADDR_W-1:OFFSET_W];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      fin_q        <= 1'b0;
      addr_ready_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_blk_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      hit_q        <= 1'b0;
      hit_cnt_q    <= '0;
      acc_cnt_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fin_q        <= fin_d;
      addr_ready_q <= addr_ready_d;
      mem_req_q    <= mem_req_d;
      mem_blk_q    <= mem_blk_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      hit_q        <= hit_d;
      hit_cnt_q    <= hit_cnt_d;
      acc_cnt_q    <= acc_cnt_d;
      done_q       <= done_d;
    end
  end

  assign addr_ready   = addr_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_blk_addr = mem_blk_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign hit          = hit_q;
  assign hit_count    = hit_cnt_q;
  assign access_count = acc_cnt_q;
  assign done         = done_q;

endmodule

// File: doc/addr_cache_ctrl.md
ADDR_CACHE_CTRL -- requirements
Module: addr_cache_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 15, word-address width from the address reader.
- INDEX_W, 10, line index width (1024 lines).
- OFFSET_W, 2, word-in-block width (4 words per block).
- CNT_W, 16, statistics counter width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous active-low reset.
- addr_valid, in, 1, upstream address present.
- addr, in, ADDR_W, word address.
- data_finish, in, 1, accompanying address is the last one.
- addr_ready, out, 1, block accepts an address; drives the reader enable.
- mem_req, out, 1, block fetch request to backing memory.
- mem_blk_addr, out, ADDR_W-OFFSET_W, block address {tag,index}.
- mem_ack, in, 1, mem_rdata valid; completes the request.
- mem_rdata, in, 128, fetched block, word 0 in bits [31:0].
- rd_valid, out, 1, one-cycle read response strobe.
- rd_data, out, 32, word at the requested address.
- hit, out, 1, qualified by rd_valid: 1 = hit, 0 = miss.
- hit_count, out, CNT_W, hits since reset.
- access_count, out, CNT_W, completed accesses since reset.
- done, out, 1, last address processed.

Function
REQ-003 Address split SHALL be offset=addr[1:0], index=addr[11:2], tag=addr[14:12] (3 bits).
REQ-004 Storage SHALL be direct-mapped: per line a valid bit, 3-bit tag and 128-bit data block.
REQ-005 FSM states SHALL be IDLE, LOOKUP, MISS, RESPOND, DONE.
REQ-006 IDLE: addr_ready=1; addr_valid=1 SHALL capture addr and data_finish, then go to LOOKUP; otherwise stay.
REQ-007 LOOKUP (exactly 1 cycle): valid&&tag match SHALL go to RESPOND with hit=1; otherwise go to MISS.
REQ-008 MISS: mem_req=1 and mem_blk_addr={tag,index} SHALL be held stable until the mem_ack cycle.
REQ-009 On mem_ack in MISS, the line SHALL be written (data, tag, valid=1) and the FSM SHALL go to RESPOND with hit=0.
REQ-010 mem_ack outside MISS SHALL be ignored.
REQ-011 RESPOND (1 cycle): rd_valid=1; rd_data = word[offset] of the line; access_count increments; hit_count increments if hit.
REQ-012 From RESPOND: next state SHALL be DONE if the captured data_finish=1, else IDLE.
REQ-013 DONE SHALL be terminal until reset: done=1, addr_ready=0, mem_req=0.
REQ-014 Latency: address accepted in cycle N -> hit rd_valid in N+2; miss rd_valid one cycle after the mem_ack cycle.
REQ-015 Counters SHALL saturate at all-ones, never wrap.
REQ-016 addr_ready SHALL be 0 in every state except IDLE; at most one access in flight.

Reset
REQ-017 rst=0 at a clock edge SHALL force IDLE and clear all valid bits, both counters, rd_valid, hit, mem_req and done; rd_data=0.
REQ-018 Reset during MISS SHALL drop mem_req the next cycle, write no line, and ignore any subsequent mem_ack.
REQ-019 Tag and data arrays SHALL need no reset.

Structure
REQ-020 A shared package SHALL hold ADDR_W/INDEX_W/OFFSET_W/tag width constants and the FSM state enum.
REQ-021 One sub-module, cache_line_store (valid/tag/data arrays, 1 write port, 1 read port), SHALL be used.

Verification
REQ-022 Reset, then addr=15'h0004, mem_ack after 3 cycles -> mem_blk_addr=13'h0001, rd_valid with hit=0, access_count=1.
REQ-023 Repeat 15'h0005 -> rd_valid two cycles after acceptance, hit=1, rd_data=mem_rdata[63:32], hit_count=1.
REQ-024 Conflict: 15'h1004 then 15'h0004 -> both miss, second mem_blk_addr=13'h0001, line retagged each time.
REQ-025 data_finish=1 with third address -> that access completes, then done=1, addr_ready=0 permanently.
REQ-026 rst=0 while mem_req=1 -> mem_req=0 next cycle; late mem_ack ignored; re-access of the same address misses.
REQ-027 Preload access_count=16'hFFFF via 65535 hits plus one more -> count stays 16'hFFFF.
